panel_keyseq: RTL and testbench
===============================

PANEL_KEYSEQ -- requirements
Module: panel_keyseq

Interface
REQ-001 Parameter HOLD, default 8: number of cycles a key output is held asserted per command.
REQ-002 Parameter TIMEOUT, default 1024: maximum number of cycles to wait for key_busy to drop.
REQ-003 Parameter GAP, default 4: number of release cycles after completion before a new command may start.
REQ-004 clk  in  1  single system clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 s_address  in  3  Avalon slave register select.
REQ-007 s_write  in  1  Avalon write strobe.
REQ-008 s_read  in  1  Avalon read strobe.
REQ-009 s_writedata  in  32  Avalon write data.
REQ-010 s_readdata  out  32  Avalon read data; combinational from s_address.
REQ-011 s_waitrequest  out  1  Avalon wait; tied to 0.
REQ-012 ext_req  in  1  external panel command request; level, held until ext_ack.
REQ-013 ext_key  in  4  key code of the external request.
REQ-014 ext_ack  out  1  one-cycle pulse when an external command completes.
REQ-015 key_busy  in  1  processor key logic is still acting on the key.
REQ-016 key_sw  out  10  one-hot key outputs. Bit 0 dep_nxt, 1 dep, 2 ex_nxt, 3 exa, 4 exe, 5 reset, 6 stop, 7 cont, 8 sta, 9 rdi.
REQ-017 ds  out  36  data switches; bit 0 is the MSB.
REQ-018 as  out  18  address switches, bits 18:35.

Function
REQ-019 Register map, write side:
- 0 CMD: [3:0] key code; [4] start.
- 1 DS[0:17] from writedata[17:0].
- 2 DS[18:35] from writedata[17:0].
- 3 AS from writedata[17:0].
- 4 CLR: [0] clears done, [1] clears timeout, [2] clears err.
REQ-020 Register map, read side: 0 returns {owner, err, timeout, done, busy} at [4:0]; 1-3 read back the registers; other addresses read 0.
REQ-021 Writes to addresses 0-3 while busy=1 are ignored entirely.
REQ-022 FSM states: IDLE, PRESS, WAIT, GAP.
REQ-023 IDLE -> PRESS on a host start with a valid code (0-9), or on ext_req=1 with a valid ext_key.
REQ-024 On entering PRESS: latch the code, set busy, clear done/timeout/err, record owner (0 host, 1 ext).
REQ-025 A host start with code 10-15 sets err=1; no FSM transition, no key asserted.
REQ-026 An ext_req with code 10-15 sets err=1 and pulses ext_ack; no key asserted.
REQ-027 Arbitration: if a host start and ext_req occur in the same IDLE cycle, the host wins; ext_req stays pending and is served in a later IDLE cycle.
REQ-028 Timing: start written in cycle T -> key_sw bit high from T+1 through T+HOLD inclusive, exactly HOLD cycles.
REQ-029 key_sw is otherwise 0 and never has more than one bit set.
REQ-030 PRESS -> WAIT after HOLD cycles; key_sw is 0 in WAIT.
REQ-031 WAIT -> GAP when key_busy=0.
REQ-032 WAIT -> GAP with timeout=1 if key_busy has stayed 1 for TIMEOUT cycles.
REQ-033 GAP lasts GAP cycles, then -> IDLE with busy=0 and done=1.
REQ-034 ext_ack pulses in the GAP->IDLE cycle when owner=1.
REQ-035 ds/as drive the registers continuously and are never changed by the FSM.
REQ-036 A CLR write has effect in any state.
REQ-037 Counters are sized for their parameter and do not wrap.

Reset
REQ-038 Reset assertion, asynchronous and at any time including mid-PRESS: state=IDLE; key_sw=0, ds=0, as=0, ext_ack=0; busy, done, timeout, err, owner all 0; counters 0.
REQ-039 After reset deassertion, the first rising clk edge may accept a command.

Verification
REQ-040 Write DS=0o123456 / 0o654321, AS=0o1000, then CMD=0x11 (dep, start), key_busy=0 -> key_sw=0x002 for exactly 8 cycles; done=1 after the 4-cycle gap; ds=0o123456654321.
REQ-041 Host CMD=0x12 and ext_req with ext_key=3 in the same cycle -> key_sw=0x004 first, then 0x008; ext_ack pulses once at the end of the second command.
REQ-042 key_busy held at 1 -> timeout=1 after 1024 WAIT cycles, then done=1; CLR writing 0x3 clears both flags.
REQ-043 CMD=0x1C -> err=1, busy stays 0, key_sw stays 0.
REQ-044 Write AS during PRESS -> write ignored; reset asserted mid-PRESS -> key_sw=0 and status=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/panel_keyseq.sv
// panel_keyseq: sequences one console key press per command, from an Avalon host or an external requester.
// Ports:
//   clk, reset (async, active-low)
//   s_address/s_write/s_read/s_writedata/s_readdata/s_waitrequest : Avalon slave (CMD, DS hi/lo, AS, CLR)
//   ext_req/ext_key/ext_ack : external level request with key code, one-cycle completion ack
//   key_busy : processor still acting on the key
//   key_sw : one-hot key outputs; ds/as : data and address switches driven from registers
module panel_keyseq #(
    parameter int HOLD    = 8,
    parameter int TIMEOUT = 1024,
    parameter int GAP     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  s_address,
    input  logic        s_write,
    input  logic        s_read,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    output logic        s_waitrequest,
    input  logic        ext_req,
    input  logic [3:0]  ext_key,
    output logic        ext_ack,
    input  logic        key_busy,
    output logic [9:0]  key_sw,
    output logic [35:0] ds,
    output logic [17:0] as
);
    typedef enum logic [1:0] {S_IDLE, S_PRESS, S_WAIT, S_GAP} state_t;

    localparam int MAXC = (HOLD > TIMEOUT) ? ((HOLD > GAP) ? HOLD : GAP) : ((TIMEOUT > GAP) ? TIMEOUT : GAP);
    localparam int CW   = $clog2(MAXC + 1);

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [3:0]    code;
    logic          owner, done, timeout, err;
    logic [17:0]   ds_hi, ds_lo, as_r;
    logic          busy, wr_ok, host_start, host_ok, host_bad, ext_take, ext_ok, ext_bad;
    logic          accept, clr, wait_to, gap_end;
    logic          unused_ok;

    assign busy       = state != S_IDLE;
    assign wr_ok      = s_write && !busy;
    assign host_start = wr_ok && s_address == 3'd0 && s_writedata[4];
    assign host_ok    = host_start && s_writedata[3:0] <= 4'd9;
    assign host_bad   = host_start && !host_ok;
    // A host start wins the IDLE cycle; ext_req is also ignored while its ack is
    // on the wire so a requester still holding the level is not served twice.
    assign ext_take   = !busy && !host_start && ext_req && !ext_ack;
    assign ext_ok     = ext_take && ext_key <= 4'd9;
    assign ext_bad    = ext_take && !ext_ok;
    assign accept     = host_ok || ext_ok;
    assign clr        = s_write && s_address == 3'd4;
    assign wait_to    = state == S_WAIT && key_busy && cnt == CW'(TIMEOUT - 1);
    assign gap_end    = state == S_GAP && cnt == CW'(GAP - 1);

    assign key_sw        = (state == S_PRESS) ? 10'(10'd1 << code) : 10'd0;
    assign ds            = {ds_hi, ds_lo};
    assign as            = as_r;
    assign s_waitrequest = 1'b0;
    assign unused_ok     = s_read ^ (^s_writedata[31:18]);

    always_comb begin
        s_readdata = (s_address == 3'd0) ? {27'd0, owner, err, timeout, done, busy} :
                     (s_address == 3'd1) ? {14'd0, ds_hi} :
                     (s_address == 3'd2) ? {14'd0, ds_lo} :
                     (s_address == 3'd3) ? {14'd0, as_r} : 32'd0;
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 1'b1;
        case (state)
            S_IDLE: begin
                cnt_nx = '0;
                if (accept) state_nx = S_PRESS;
            end
            S_PRESS: if (cnt == CW'(HOLD - 1)) begin
                state_nx = S_WAIT;
                cnt_nx   = '0;
            end
            S_WAIT: if (!key_busy || wait_to) begin
                state_nx = S_GAP;
                cnt_nx   = '0;
            end
            S_GAP: if (gap_end) begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            code    <= '0;
            owner   <= 1'b0;
            done    <= 1'b0;
            timeout <= 1'b0;
            err     <= 1'b0;
            ds_hi   <= '0;
            ds_lo   <= '0;
            as_r    <= '0;
            ext_ack <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            ext_ack <= (gap_end && owner) || ext_bad;
            if (wr_ok && s_address == 3'd1) ds_hi <= s_writedata[17:0];
            if (wr_ok && s_address == 3'd2) ds_lo <= s_writedata[17:0];
            if (wr_ok && s_address == 3'd3) as_r  <= s_writedata[17:0];
            if (accept) begin
                code    <= host_ok ? s_writedata[3:0] : ext_key;
                owner   <= ext_ok;
                done    <= 1'b0;
                timeout <= 1'b0;
                err     <= 1'b0;
            end else begin
                if (clr && s_writedata[0]) done    <= 1'b0;
                if (clr && s_writedata[1]) timeout <= 1'b0;
                if (clr && s_writedata[2]) err     <= 1'b0;
                // Events in the same cycle as a CLR take precedence over it.
                if (host_bad || ext_bad) err     <= 1'b1;
                if (wait_to)             timeout <= 1'b1;
                if (gap_end)             done    <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_panel_keyseq.sv
// tb_panel_keyseq: self-checking bench for panel_keyseq using an expected/observed key-pulse scoreboard.
module tb_panel_keyseq;
    typedef struct {
        logic [9:0] v;
        int         len;
    } pulse_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  s_address = '0;
    logic        s_write = 1'b0;
    logic        s_read = 1'b0;
    logic [31:0] s_writedata = '0;
    logic [31:0] s_readdata;
    logic        s_waitrequest;
    logic        ext_req = 1'b0;
    logic [3:0]  ext_key = '0;
    logic        ext_ack;
    logic        key_busy = 1'b0;
    logic [9:0]  key_sw;
    logic [35:0] ds;
    logic [17:0] as;

    int     n_tests = 0;
    int     n_fail = 0;
    int     ack_cnt = 0;
    int     bad_onehot = 0;
    int     cur_len = 0;
    logic [9:0] cur = '0;
    pulse_t exp_q[$];
    pulse_t obs_q[$];

    panel_keyseq dut (
        .clk(clk), .reset(reset),
        .s_address(s_address), .s_write(s_write), .s_read(s_read),
        .s_writedata(s_writedata), .s_readdata(s_readdata), .s_waitrequest(s_waitrequest),
        .ext_req(ext_req), .ext_key(ext_key), .ext_ack(ext_ack),
        .key_busy(key_busy), .key_sw(key_sw), .ds(ds), .as(as)
    );

    always #5 clk = ~clk;

    // Record every key pulse (value and length in cycles) and every ack cycle.
    always @(negedge clk) begin
        if ($countones(key_sw) > 1) bad_onehot++;
        if (ext_ack) ack_cnt++;
        if (key_sw != 10'd0 && key_sw == cur) cur_len++;
        else begin
            if (cur != 10'd0) obs_q.push_back('{cur, cur_len});
            cur     = key_sw;
            cur_len = (key_sw != 10'd0) ? 1 : 0;
        end
    end

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        s_write = 1'b1; s_address = a; s_writedata = d;
        @(negedge clk);
        s_write = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        s_address = a;
        #1 d = s_readdata;
    endtask

    // Cycles until done reads 1, or -1 when the budget runs out.
    task automatic wait_done(input int budget, output int n);
        s_address = 3'd0;
        #1;
        for (n = 0; n < budget; n++) begin
            if (s_readdata[1]) return;
            @(negedge clk);
            #1;
        end
        n = -1;
    endtask

    task automatic wait_ack(input int budget, output int n);
        for (n = 0; n < budget; n++) begin
            @(negedge clk);
            if (ext_ack) begin
                ext_req = 1'b0;
                return;
            end
        end
        ext_req = 1'b0;
        n = -1;
    endtask

    task automatic test_reset;
        logic [31:0] st;
        rd(3'd0, st);
        n_tests++; if (st !== 32'd0) begin n_fail++; $display("FAIL reset_status got %h want 0", st); end
        n_tests++; if (key_sw !== 10'd0 || ext_ack !== 1'b0 || s_waitrequest !== 1'b0) begin
            n_fail++; $display("FAIL reset_outputs key_sw=%h ack=%b wait=%b want 0", key_sw, ext_ack, s_waitrequest); end
        n_tests++; if (ds !== 36'd0 || as !== 18'd0) begin n_fail++; $display("FAIL reset_switches ds=%o as=%o want 0", ds, as); end
    endtask

    task automatic test_dep;
        logic [31:0] d;
        int n;
        pulse_t e, o;
        wr(3'd1, 32'o123456);
        wr(3'd2, 32'o654321);
        wr(3'd3, 32'o1000);
        n_tests++; if (ds !== 36'o123456654321 || as !== 18'o1000) begin
            n_fail++; $display("FAIL dep_switches ds=%o as=%o want 123456654321/1000", ds, as); end
        rd(3'd1, d);
        n_tests++; if (d !== 32'o123456) begin n_fail++; $display("FAIL dep_readback got %o want 123456", d); end
        exp_q.push_back('{10'h002, 8});
        wr(3'd0, 32'h11);
        n_tests++; if (key_sw !== 10'h002) begin n_fail++; $display("FAIL dep_first_cycle key_sw=%h want 002", key_sw); end
        wait_done(100, n);
        n_tests++; if (n !== 13) begin n_fail++; $display("FAIL dep_done_latency got %0d want 13", n); end
        rd(3'd0, d);
        n_tests++; if (d !== 32'h2) begin n_fail++; $display("FAIL dep_status got %h want 2", d); end
        e = exp_q.pop_front();
        n_tests++;
        if (obs_q.size() == 0) begin n_fail++; $display("FAIL dep_pulse got none want %h x%0d", e.v, e.len); end
        else begin
            o = obs_q.pop_front();
            if (o.v !== e.v || o.len != e.len) begin n_fail++; $display("FAIL dep_pulse got %h x%0d want %h x%0d", o.v, o.len, e.v, e.len); end
        end
    endtask

    task automatic test_arbitration;
        logic [31:0] d;
        int n;
        pulse_t e, o;
        ack_cnt = 0;
        exp_q.push_back('{10'h004, 8});
        exp_q.push_back('{10'h008, 8});
        @(negedge clk);
        ext_req = 1'b1; ext_key = 4'd3;
        s_write = 1'b1; s_address = 3'd0; s_writedata = 32'h12;
        @(negedge clk);
        s_write = 1'b0;
        wait_ack(200, n);
        n_tests++; if (n < 0) begin n_fail++; $display("FAIL arb_ack_wait got timeout want ack"); end
        repeat (20) @(negedge clk);
        n_tests++; if (ack_cnt != 1) begin n_fail++; $display("FAIL arb_ack_count got %0d want 1", ack_cnt); end
        rd(3'd0, d);
        n_tests++; if (d !== 32'h12) begin n_fail++; $display("FAIL arb_status got %h want 12", d); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL arb_pulse got none want %h x%0d", e.v, e.len); end
            else begin
                o = obs_q.pop_front();
                if (o.v !== e.v || o.len != e.len) begin n_fail++; $display("FAIL arb_pulse got %h x%0d want %h x%0d", o.v, o.len, e.v, e.len); end
            end
        end
    endtask

    task automatic test_timeout;
        logic [31:0] d;
        int n;
        pulse_t e, o;
        key_busy = 1'b1;
        exp_q.push_back('{10'h010, 8});
        wr(3'd0, 32'h14);
        wait_done(1200, n);
        n_tests++; if (n !== 1036) begin n_fail++; $display("FAIL timeout_latency got %0d want 1036", n); end
        rd(3'd0, d);
        n_tests++; if (d !== 32'h6) begin n_fail++; $display("FAIL timeout_status got %h want 6", d); end
        key_busy = 1'b0;
        wr(3'd4, 32'h3);
        rd(3'd0, d);
        n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL timeout_clear got %h want 0", d); end
        e = exp_q.pop_front();
        n_tests++;
        if (obs_q.size() == 0) begin n_fail++; $display("FAIL timeout_pulse got none want %h x%0d", e.v, e.len); end
        else begin
            o = obs_q.pop_front();
            if (o.v !== e.v || o.len != e.len) begin n_fail++; $display("FAIL timeout_pulse got %h x%0d want %h x%0d", o.v, o.len, e.v, e.len); end
        end
    endtask

    task automatic test_bad_code;
        logic [31:0] d;
        int n;
        wr(3'd0, 32'h1C);
        repeat (12) @(negedge clk);
        rd(3'd0, d);
        n_tests++; if (d !== 32'h8) begin n_fail++; $display("FAIL bad_host_status got %h want 8", d); end
        n_tests++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL bad_host_keys got %0d pulses want 0", obs_q.size()); end
        wr(3'd4, 32'h4);
        rd(3'd0, d);
        n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL bad_clear got %h want 0", d); end
        ack_cnt = 0;
        @(negedge clk);
        ext_req = 1'b1; ext_key = 4'd12;
        wait_ack(20, n);
        repeat (12) @(negedge clk);
        rd(3'd0, d);
        n_tests++; if (d !== 32'h8 || ack_cnt != 1) begin n_fail++; $display("FAIL bad_ext status=%h acks=%0d want 8/1", d, ack_cnt); end
        n_tests++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL bad_ext_keys got %0d pulses want 0", obs_q.size()); end
        wr(3'd4, 32'h4);
    endtask

    task automatic test_busy_write_and_reset;
        logic [31:0] d;
        int n;
        wr(3'd3, 32'o777);
        wr(3'd0, 32'h15);
        wr(3'd3, 32'o1234);
        n_tests++; if (as !== 18'o777) begin n_fail++; $display("FAIL busy_write as=%o want 777", as); end
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        n_tests++; if (key_sw !== 10'd0) begin n_fail++; $display("FAIL reset_mid_press key_sw=%h want 0", key_sw); end
        rd(3'd0, d);
        n_tests++; if (d !== 32'd0 || ds !== 36'd0 || as !== 18'd0) begin
            n_fail++; $display("FAIL reset_mid_press status=%h ds=%o as=%o want 0", d, ds, as); end
        @(negedge clk);
        @(negedge clk);
        obs_q.delete();
        exp_q.delete();
        reset = 1'b1;
        s_write = 1'b1; s_address = 3'd0; s_writedata = 32'h11;
        @(negedge clk);
        s_write = 1'b0;
        n_tests++; if (key_sw !== 10'h002) begin n_fail++; $display("FAIL first_edge key_sw=%h want 002", key_sw); end
        wait_done(100, n);
        n_tests++; if (n !== 13) begin n_fail++; $display("FAIL first_edge_done got %0d want 13", n); end
        n_tests++; if (bad_onehot != 0) begin n_fail++; $display("FAIL onehot got %0d bad cycles want 0", bad_onehot); end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1'b1;
        test_dep();
        test_arbitration();
        test_timeout();
        test_bad_code();
        test_busy_write_and_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
